shared_reg_arbiter: RTL and testbench



---
 rtl/shared_reg_arbiter.sv | 110 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin sharing of one data register among N
// requesters; each grant loads q, then q is held for HOLD cycles.
module shared_reg_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int HOLD = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           q_valid,
    output logic [IW-1:0]  owner,
    output logic           busy
);
    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  q_q, q_d;
    logic          q_valid_q, q_valid_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;

    logic [W-1:0]  wd [N];
    logic [IW-1:0] win;
    logic [IW-1:0] idx;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            wd[i] = wdata[i*W +: W];
        end
    end

    // Scan from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        win = last_q;
        idx = last_q;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last_q) + k) % N);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        owner_d   = owner_q;
        last_d    = last_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d[win] = 1'b1;
                    q_d        = wd[win];
                    q_valid_d  = 1'b1;
                    owner_d    = win;
                    last_d     = win;
                    cnt_d      = CW'(HOLD);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            owner_q   <= '0;
            last_q    <= IW'(N - 1);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign owner   = owner_q;
    assign busy    = (state_q == BUSY);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed plan plus random traffic, checked
// against a cycle-level reference model of the arbiter's rules.
module tb_shared_reg_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int HOLD = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [W-1:0]   wd [N];
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [1:0]     owner;
    logic           busy;

    assign wdata = {wd[3], wd[2], wd[1], wd[0]};

    shared_reg_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .wdata(wdata),
        .gnt(gnt),
        .q(q),
        .q_valid(q_valid),
        .owner(owner),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit log_en = 0;
    int g_idx[$];
    int g_cyc[$];
    logic [W-1:0] g_q[$];

    // reference model state
    int           m_left;
    int           m_last;
    logic [N-1:0] m_gnt;
    logic [W-1:0] m_q;
    logic         m_valid;
    int           m_owner;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_last  = N - 1;
        m_gnt   = '0;
        m_q     = '0;
        m_valid = 1'b0;
        m_owner = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (m_left > 0) begin
            m_gnt = '0;
            m_left--;
        end else begin
            m_gnt = '0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req[2'(c)]) begin
                    m_gnt   = 4'(1) << c;
                    m_q     = wd[c];
                    m_valid = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_left  = HOLD;
                    break;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'(m_gnt));
        check({tag, "_q"}, 32'(q), 32'(m_q));
        check({tag, "_qv"}, 32'(q_valid), 32'(m_valid));
        check({tag, "_owner"}, 32'(owner), 32'(m_owner));
        check({tag, "_busy"}, 32'(busy), 32'(m_left > 0));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
        cyc++;
        if (log_en && gnt != '0) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) g_idx.push_back(i);
            end
            g_cyc.push_back(cyc);
            g_q.push_back(q);
        end
    endtask

    task automatic drop_granted();
        req = req & ~m_gnt;
    endtask

    task automatic clear_log();
        g_idx.delete();
        g_cyc.delete();
        g_q.delete();
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        model_reset();
        #1;
        compare_all(tag);
        step({tag, "_hold"});
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) wd[i] = W'($urandom);
        model_reset();

        // reset with all requests high, checked before any clock edge
        req = 4'b1111;
        #1;
        reset = 1'b1;
        #1;
        compare_all("rst_async");
        check("rst_q_zero", 32'(q), 32'h0);
        step("rst_hold1");
        step("rst_hold2");
        reset = 1'b0;
        req = 4'b0000;

        // single request
        req = 4'b0010;
        wd[1] = 8'hA5;
        step("single");
        check("single_gnt", 32'(gnt), 32'b0010);
        check("single_q_a5", 32'(q), 32'hA5);
        check("single_owner", 32'(owner), 32'd1);
        drop_granted();
        step("single_b1");
        step("single_b2");
        step("single_idle");
        check("single_hold_q", 32'(q), 32'hA5);
        check("single_idle_busy", 32'(busy), 32'd0);

        // fairness under continuous requests
        pulse_reset("fair_rst");
        for (int i = 0; i < N; i++) wd[i] = 8'(8'h10 + i);
        req = 4'b1111;
        clear_log();
        log_en = 1;
        repeat (13) step("fair");
        log_en = 0;
        req = 4'b0000;
        check("fair_count", 32'(g_idx.size()), 32'd5);
        for (int j = 0; j < 5 && j < g_idx.size(); j++) begin
            check("fair_idx", 32'(g_idx[j]), 32'(j % 4));
            check("fair_q", 32'(g_q[j]), 32'(8'h10 + (j % 4)));
            if (j > 0) check("fair_gap", 32'(g_cyc[j] - g_cyc[j-1]), 32'd3);
        end
        step("fair_b1");
        step("fair_b2");

        // wrap priority: last grantee 1, then requesters 0 and 2 together
        req = 4'b0010;
        step("wrap_pre");
        drop_granted();
        step("wrap_pre_b1");
        step("wrap_pre_b2");
        req = 4'b0101;
        clear_log();
        log_en = 1;
        for (int s = 0; s < 8; s++) begin
            step("wrap");
            drop_granted();
        end
        log_en = 0;
        check("wrap_count", 32'(g_idx.size()), 32'd2);
        if (g_idx.size() >= 2) begin
            check("wrap_first", 32'(g_idx[0]), 32'd2);
            check("wrap_second", 32'(g_idx[1]), 32'd0);
            check("wrap_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
        end

        // request raised only during BUSY, then dropped
        req = 4'b0001;
        step("drop_grant");
        drop_granted();
        req = 4'b1000;
        step("drop_b1");
        req = 4'b0000;
        clear_log();
        log_en = 1;
        repeat (4) step("drop_idle");
        log_en = 0;
        check("drop_no_gnt", 32'(g_idx.size()), 32'd0);
        check("drop_q", 32'(q), 32'h10);

        // reset one cycle after a grant to requester 3
        req = 4'b1000;
        wd[3] = 8'h3C;
        step("mid_grant");
        check("mid_owner3", 32'(owner), 32'd3);
        drop_granted();
        step("mid_busy");
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("mid_rst");
        check("mid_rst_busy", 32'(busy), 32'd0);
        step("mid_rst_hold");
        reset = 1'b0;
        req = 4'b1001;
        step("mid_after");
        check("mid_after_gnt", 32'(gnt), 32'b0001);
        drop_granted();

        // random traffic
        for (int s = 0; s < 600; s++) begin
            step("rand");
            if (reset) reset = 1'b0;
            drop_granted();
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 4 == 0)) begin
                    req[i] = 1'b1;
                    wd[i]  = W'($urandom);
                end else if (req[i] && ($urandom % 16 == 0)) begin
                    req[i] = 1'b0;
                end
            end
            if ($urandom % 100 == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                compare_all("rand_rst");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
